// File: rtl/control_riego.sv
// control_riego -- irrigation sequencer between the sensor frame decoder and
// the water-pump driver.
//
// Latches each decoded humidity sample, compares it against a per-plant-type
// start threshold with a hysteresis band for stopping, drives the pump with a
// bounded on-time followed by a mandatory soak pause, and latches a fault
// after repeated on-time expiries (dry sensor or no water).
//
// Optional feature macro: RIEGO_HORARIO_EN
//   defined   : EVAL refuses to start the pump while the latched hour
//               (BCD hora_i[15:8]) lies in the night window [22h,06h).
//   undefined : hora_i is ignored.
//
// Ports
//   clk_i          system clock
//   rst_n_i        synchronous reset, active low
//   listo_i        1-cycle pulse: humedad_i/tipo_planta_i/hora_i valid
//   humedad_i      humidity sample, larger = wetter
//   tipo_planta_i  plant type selector
//   hora_i         BCD HHMM time of day
//   mod_bomba_i    pump module physically connected
//   activar_b_o    pump enable
//   regar_o        alarm/melody request
//   falla_o        latched fault
//   estado_o       FSM state code
//   ciclos_o       completed pump cycles, saturating at 255
//
// state  | code | meaning
// IDLE   | 0    | waiting for a sample
// EVAL   | 1    | one-cycle decision on the latched sample
// RIEGO  | 2    | pump on, bounded by T_ON_MAX ticks
// REPOSO | 3    | soak pause of T_REPOSO ticks, pump off
// FALLA  | 4    | fault latched, left only by reset

module control_riego #(
  parameter int unsigned TICK_CYC    = 50_000,
  parameter int unsigned T_ON_MAX    = 5000,
  parameter int unsigned T_REPOSO    = 20000,
  parameter logic [11:0] UMBRAL_BASE = 12'd800,
  parameter logic [11:0] UMBRAL_PASO = 12'd150,
  parameter logic [11:0] HIST        = 12'd200,
  parameter int unsigned FALLA_MAX   = 3
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        listo_i,
  input  logic [11:0] humedad_i,
  input  logic [3:0]  tipo_planta_i,
  input  logic [15:0] hora_i,
  input  logic        mod_bomba_i,
  output logic        activar_b_o,
  output logic        regar_o,
  output logic        falla_o,
  output logic [2:0]  estado_o,
  output logic [7:0]  ciclos_o
);

  localparam int unsigned PW   = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam int unsigned TMAX = (T_ON_MAX > T_REPOSO) ? T_ON_MAX : T_REPOSO;
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam int unsigned CW   = (FALLA_MAX > 0) ? $clog2(FALLA_MAX + 1) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    EVAL   = 3'd1,
    RIEGO  = 3'd2,
    REPOSO = 3'd3,
    FALLA  = 3'd4
  } estado_t;

  // Free-running tick prescaler (down-counter, tick on terminal count).
  logic [PW-1:0] presc_q;
  logic          tick;

  assign tick = (presc_q == '0);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      presc_q <= '0;
    end else if (tick) begin
      presc_q <= PW'(TICK_CYC - 1);
    end else begin
      presc_q <= presc_q - PW'(1);
    end
  end

  // Sample latch and thresholds.
  logic [11:0] hum_q;
  logic [3:0]  tipo_q;
  logic        valid_q;
  logic [16:0] on_sum;
  logic [12:0] off_sum;
  logic [11:0] u_on_d;
  logic [11:0] u_off_d;
  logic [11:0] u_off_q;

  assign on_sum  = 17'(UMBRAL_BASE) + 17'(tipo_q) * 17'(UMBRAL_PASO);
  assign u_on_d  = (on_sum > 17'h00FFF) ? 12'hFFF : on_sum[11:0];
  assign off_sum = 13'(u_on_d) + 13'(HIST);
  assign u_off_d = off_sum[12] ? 12'hFFF : off_sum[11:0];

  // u_off lags the latched plant type by one cycle, so a type change carried
  // by a listo inside RIEGO only affects the stop compare from the next listo.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      hum_q   <= '0;
      tipo_q  <= '0;
      valid_q <= 1'b0;
      u_off_q <= '0;
    end else begin
      if (listo_i) begin
        hum_q   <= humedad_i;
        tipo_q  <= tipo_planta_i;
        valid_q <= 1'b1;
      end
      u_off_q <= u_off_d;
    end
  end

  // Time-of-day gate.
  logic en_ventana;

`ifdef RIEGO_HORARIO_EN
  logic [7:0] hora_h_q;
  logic       unused_hora_min;

  assign unused_hora_min = ^hora_i[7:0];

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      hora_h_q <= '0;
    end else if (listo_i) begin
      hora_h_q <= hora_i[15:8];
    end
  end

  // BCD hours compare correctly as plain unsigned bytes.
  assign en_ventana = (hora_h_q >= 8'h22) || (hora_h_q < 8'h06);
`else
  logic unused_hora;

  assign unused_hora = ^hora_i;
  assign en_ventana  = 1'b0;
`endif

  // Sequencer with registered outputs.
  estado_t       estado_q;
  logic [TW-1:0] tmr_q;
  logic [CW-1:0] fallos_q;
  logic [7:0]    ciclos_q;
  logic          activar_q;
  logic          regar_q;
  logic          falla_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      estado_q  <= IDLE;
      tmr_q     <= '0;
      fallos_q  <= '0;
      ciclos_q  <= '0;
      activar_q <= 1'b0;
      regar_q   <= 1'b0;
      falla_q   <= 1'b0;
    end else begin
      case (estado_q)
        IDLE: begin
          if (listo_i) estado_q <= EVAL;
        end

        // EVAL runs the cycle right after the latch, before u_on could be
        // registered, so it uses the combinational threshold.
        EVAL: begin
          if (!mod_bomba_i || !valid_q || en_ventana) begin
            estado_q <= IDLE;
          end else if (hum_q < u_on_d) begin
            estado_q  <= RIEGO;
            tmr_q     <= '0;
            activar_q <= 1'b1;
            regar_q   <= 1'b1;
          end else begin
            estado_q <= IDLE;
          end
        end

        // Priority: pump removal, then wet sample, then on-time expiry.
        RIEGO: begin
          if (!mod_bomba_i) begin
            estado_q  <= IDLE;
            activar_q <= 1'b0;
            regar_q   <= 1'b0;
          end else if (listo_i && (humedad_i >= u_off_q)) begin
            estado_q  <= REPOSO;
            tmr_q     <= '0;
            fallos_q  <= '0;
            activar_q <= 1'b0;
            regar_q   <= 1'b0;
            if (ciclos_q != 8'hFF) ciclos_q <= ciclos_q + 8'd1;
          end else if (tick && (tmr_q == TW'(T_ON_MAX - 1))) begin
            estado_q  <= REPOSO;
            tmr_q     <= '0;
            activar_q <= 1'b0;
            regar_q   <= 1'b0;
            if (fallos_q != CW'(FALLA_MAX)) fallos_q <= fallos_q + CW'(1);
            if (ciclos_q != 8'hFF) ciclos_q <= ciclos_q + 8'd1;
          end else if (tick && (tmr_q != TW'(T_ON_MAX))) begin
            tmr_q <= tmr_q + TW'(1);
          end
        end

        REPOSO: begin
          if (tick) begin
            if (tmr_q == TW'(T_REPOSO - 1)) begin
              if (fallos_q == CW'(FALLA_MAX)) begin
                estado_q <= FALLA;
                falla_q  <= 1'b1;
                regar_q  <= 1'b1;
              end else begin
                estado_q <= IDLE;
              end
            end else if (tmr_q != TW'(T_REPOSO)) begin
              tmr_q <= tmr_q + TW'(1);
            end
          end
        end

        FALLA: begin
          activar_q <= 1'b0;
          regar_q   <= 1'b1;
          falla_q   <= 1'b1;
        end

        default: begin
          estado_q <= IDLE;
        end
      endcase
    end
  end

  assign activar_b_o = activar_q;
  assign regar_o     = regar_q;
  assign falla_o     = falla_q;
  assign estado_o    = estado_q;
  assign ciclos_o    = ciclos_q;

endmodule

// File: tb/tb_control_riego.sv
// Directed bench for control_riego with a short timebase
// (TICK_CYC=4, T_ON_MAX=10, T_REPOSO=8, FALLA_MAX=2).
// Ticks fall on the edges whose index since reset release is a multiple of 4,
// so timed intervals are predicted from the edge index at which they start.

module tb_control_riego;

  localparam int TICK = 4;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        listo_i;
  logic [11:0] humedad_i;
  logic [3:0]  tipo_planta_i;
  logic [15:0] hora_i;
  logic        mod_bomba_i;
  logic        activar_b_o;
  logic        regar_o;
  logic        falla_o;
  logic [2:0]  estado_o;
  logic [7:0]  ciclos_o;

  int nvec = 0;
  int nerr = 0;
  int ecnt = 0;
  int exp_cic = 0;
  int t0 = 0;

  control_riego #(
    .TICK_CYC (4),
    .T_ON_MAX (10),
    .T_REPOSO (8),
    .FALLA_MAX(2)
  ) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .listo_i      (listo_i),
    .humedad_i    (humedad_i),
    .tipo_planta_i(tipo_planta_i),
    .hora_i       (hora_i),
    .mod_bomba_i  (mod_bomba_i),
    .activar_b_o  (activar_b_o),
    .regar_o      (regar_o),
    .falla_o      (falla_o),
    .estado_o     (estado_o),
    .ciclos_o     (ciclos_o)
  );

  always #5 clk_i = ~clk_i;

  // Value before an edge = index of that edge since reset release.
  always @(posedge clk_i) begin
    if (!rst_n_i) ecnt <= 0;
    else          ecnt <= ecnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clkn(input int n);
    repeat (n) clk1();
  endtask

  task automatic enviar(input int hum, input int tipo);
    humedad_i     = 12'(hum);
    tipo_planta_i = 4'(tipo);
    listo_i       = 1'b1;
    clk1();
    listo_i       = 1'b0;
  endtask

  task automatic wait_leave(input logic [2:0] st, input string tag);
    int n = 0;
    while (estado_o == st && n < 300) begin
      clk1();
      n++;
    end
    chk({tag, "_bound"}, 32'(n < 300), 1);
  endtask

  // Edges from entry (edge a) to the edge counting the t-th tick after it.
  function automatic int exp_dur(input int a, input int t);
    int t1;
    t1 = (a / TICK + 1) * TICK;
    return t1 + (t - 1) * TICK - a;
  endfunction

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    rst_n_i       = 1'b0;
    listo_i       = 1'b0;
    humedad_i     = '0;
    tipo_planta_i = '0;
    hora_i        = 16'h1200;
    mod_bomba_i   = 1'b1;

    // Reset held for 3 clocks while listo pulses.
    for (int i = 0; i < 3; i++) begin
      listo_i   = (i != 1);
      humedad_i = 12'd100;
      clk1();
    end
    chk("rst_activar", activar_b_o, 0);
    chk("rst_regar",   regar_o,     0);
    chk("rst_falla",   falla_o,     0);
    chk("rst_estado",  estado_o,    0);
    chk("rst_ciclos",  ciclos_o,    0);
    listo_i = 1'b0;
    rst_n_i = 1'b1;

    // Humidity equal to u_on (800) does not start the pump.
    enviar(800, 0);
    chk("eval_state", estado_o, 1);
    clk1();
    chk("eq_uon_idle", estado_o, 0);
    chk("eq_uon_act", activar_b_o, 0);

    // No pump module: EVAL falls back to IDLE.
    mod_bomba_i = 1'b0;
    enviar(100, 0);
    clk1();
    chk("nobomba_idle", estado_o, 0);
    mod_bomba_i = 1'b1;

    // Test 2: start at 500, stop at 1000 (u_off for tipo 0).
    enviar(500, 0);
    chk("t2_act_1clk", activar_b_o, 0);
    clk1();
    chk("t2_act_2clk", activar_b_o, 1);
    chk("t2_riego",    estado_o,    2);
    chk("t2_regar",    regar_o,     1);
    clkn(3);
    enviar(1000, 0);
    t0 = ecnt;
    exp_cic++;
    chk("t2_off_act",   activar_b_o, 0);
    chk("t2_reposo",    estado_o,    3);
    chk("t2_ciclos",    ciclos_o,    exp_cic);
    chk("t2_regar_off", regar_o,     0);
    clkn(2);
    enviar(100, 0);
    chk("t2_listo_in_reposo", estado_o, 3);
    wait_leave(3'd3, "t2_reposo");
    chk("t2_reposo_dur", ecnt - t0, exp_dur(t0 - 1, 8));
    chk("t2_idle", estado_o, 0);

    // Test 3: tipo 2, u_on=1100, u_off=1300.
    enviar(1050, 2);
    clk1();
    chk("t3_riego", estado_o, 2);
    clkn(2);
    enviar(1200, 2);
    chk("t3_1200_on", activar_b_o, 1);
    clkn(2);
    enviar(1299, 2);
    chk("t3_1299_on", estado_o, 2);
    clkn(2);
    enviar(1300, 2);
    exp_cic++;
    chk("t3_1300_off", activar_b_o, 0);
    chk("t3_reposo",   estado_o,    3);
    chk("t3_ciclos",   ciclos_o,    exp_cic);
    wait_leave(3'd3, "t3_reposo");
    chk("t3_idle", estado_o, 0);

    // Plant type change mid-RIEGO: new u_off only from the following listo.
    enviar(1050, 2);
    clk1();
    chk("t3b_riego", estado_o, 2);
    enviar(1250, 0);
    chk("t3b_old_uoff", estado_o, 2);
    clkn(2);
    enviar(1250, 0);
    exp_cic++;
    chk("t3b_new_uoff", estado_o, 3);
    wait_leave(3'd3, "t3b_reposo");

    // Test 5: pump module removed during RIEGO.
    enviar(100, 0);
    clk1();
    chk("t5_riego", estado_o, 2);
    clkn(3);
    mod_bomba_i = 1'b0;
    clk1();
    chk("t5_act",    activar_b_o, 0);
    chk("t5_idle",   estado_o,    0);
    chk("t5_ciclos", ciclos_o,    exp_cic);
    chk("t5_regar",  regar_o,     0);
    mod_bomba_i = 1'b1;

`ifdef RIEGO_HORARIO_EN
    // Test 6: night window blocks a start but not a running cycle.
    hora_i = 16'h2330;
    enviar(100, 0);
    clk1();
    chk("t6_night_idle", estado_o, 0);
    hora_i = 16'h0700;
    enviar(100, 0);
    clk1();
    chk("t6_day_riego", estado_o, 2);
    hora_i = 16'h2330;
    enviar(500, 0);
    chk("t6_running_kept", estado_o, 2);
    enviar(1000, 0);
    exp_cic++;
    chk("t6_stop", estado_o, 3);
    wait_leave(3'd3, "t6_reposo");
    hora_i = 16'h1200;
`endif

    // Test 4: dry sensor, two on-time expiries lead to the fault.
    enviar(100, 0);
    clk1();
    t0 = ecnt;
    chk("t4_riego1", estado_o, 2);
    clkn(5);
    enviar(100, 0);
    wait_leave(3'd2, "t4_on1");
    exp_cic++;
    chk("t4_on1_dur",    ecnt - t0, exp_dur(t0 - 1, 10));
    chk("t4_on1_reposo", estado_o,  3);
    chk("t4_on1_ciclos", ciclos_o,  exp_cic);
    wait_leave(3'd3, "t4_reposo1");
    chk("t4_idle",   estado_o, 0);
    chk("t4_nofall", falla_o,  0);

    enviar(100, 0);
    clk1();
    t0 = ecnt;
    chk("t4_riego2", estado_o, 2);
    wait_leave(3'd2, "t4_on2");
    exp_cic++;
    chk("t4_on2_dur", ecnt - t0, exp_dur(t0 - 1, 10));
    wait_leave(3'd3, "t4_reposo2");
    chk("t4_falla_est", estado_o,    4);
    chk("t4_falla",     falla_o,     1);
    chk("t4_regar",     regar_o,     1);
    chk("t4_act",       activar_b_o, 0);
    chk("t4_ciclos",    ciclos_o,    exp_cic);
    enviar(100, 0);
    clkn(5);
    chk("t4_falla_hold", estado_o,    4);
    chk("t4_act_hold",   activar_b_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
